utils_divider_32: RTL and testbench

- Iterative radix-2 restoring divider. It is the division counterpart to the team's combinational Booth/compressor multiplier.
- Implements the RISC-V M-extension DIV, DIVU, REM and REMU operations for the TPU scalar/ALU path.
- Accepts one operation per valid/ready handshake. Returns the quotient or remainder after a fixed number of cycles, using a valid/ready output handshake.
- Inputs are registered, so the block drops into a pipelined ALU without extra staging.

---
 rtl/utils_div_pkg.sv | 32 +++
 rtl/utils_div_step.sv | 33 +++
 rtl/utils_divider_32.sv | 163 ++++++++++++++++
 tb/tb_utils_divider_32.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/utils_div_pkg.sv
// ---------------------------------------------------------------------------
// utils_div_pkg
// Shared definitions for the iterative restoring divider (utils_divider_32).
//   - DIV_MODE_* : operation codes presented on div_mode_i
//   - state_e    : divider control state encoding
//   - clog2()    : width of the iteration counter for a given DW
// ---------------------------------------------------------------------------
package utils_div_pkg;

  localparam logic [2:0] DIV_MODE_DIV  = 3'b100;
  localparam logic [2:0] DIV_MODE_DIVU = 3'b101;
  localparam logic [2:0] DIV_MODE_REM  = 3'b110;
  localparam logic [2:0] DIV_MODE_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Smallest r with 2**r >= value (value >= 2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/utils_div_step.sv
// ---------------------------------------------------------------------------
// utils_div_step
// One combinational restoring-division iteration.
// Ports:
//   rem_i   [DW] partial remainder entering this iteration (always < dvs_i)
//   msb_i   [1]  next dividend bit, shifted into the remainder LSB
//   dvs_i   [DW] divisor magnitude
//   rem_o   [DW] partial remainder after the conditional subtract
//   q_o     [1]  quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module utils_div_step
  import utils_div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem_i,
  input  logic          msb_i,
  input  logic [DW-1:0] dvs_i,
  output logic [DW-1:0] rem_o,
  output logic          q_o
);

  logic [DW:0] rem_sh;
  logic [DW:0] diff;

  // rem_i < dvs_i guarantees rem_sh < 2*dvs_i, so one extra bit is enough
  // and a successful subtract always fits back into DW bits.
  assign rem_sh = {rem_i, msb_i};
  assign diff   = rem_sh - {1'b0, dvs_i};
  assign q_o    = ~diff[DW];
  assign rem_o  = q_o ? diff[DW-1:0] : rem_sh[DW-1:0];

endmodule

// File: rtl/utils_divider_32.sv
// ---------------------------------------------------------------------------
// utils_divider_32
// Iterative radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU.
// One bit per cycle; result after DW+2 cycles (1 cycle for divide-by-zero).
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   flush_i      synchronous abort back to IDLE
//   in_valid_i   request; accepted when in_ready_o is high
//   in_ready_o   high only in IDLE
//   div_mode_i   100 div, 101 divu, 110 rem, 111 remu (others act as divu)
//   operand1_i   dividend
//   operand2_i   divisor
//   out_valid_o  result available (held until out_ready_i)
//   out_ready_i  consumer accepts result
//   res_o        quotient or remainder
//   div_zero_o   divisor was zero
// Build option: define UTILS_DIV_EARLY_OUT_EN to skip the iterations when
// |divisor| > |dividend| (quotient 0, remainder = dividend).
// ---------------------------------------------------------------------------
module utils_divider_32
  import utils_div_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [2:0]    div_mode_i,
  input  logic [DW-1:0] operand1_i,
  input  logic [DW-1:0] operand2_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] res_o,
  output logic          div_zero_o
);

  localparam int CW = clog2(DW);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  state_e        state_q, state_d;
  logic [DW-1:0] dq_q;      // dividend bits shift out, quotient bits shift in
  logic [DW-1:0] rem_q;
  logic [DW-1:0] dvs_q;
  logic [DW-1:0] res_q;
  logic [CW-1:0] cnt_q;
  logic          is_rem_q, q_neg_q, r_neg_q, dz_q;

  logic          accept, signed_op, is_rem_op, s1, s2, div_zero, early;
  logic [DW-1:0] abs1, abs2, step_rem, q_final, r_final;
  logic          step_q;

  assign accept    = in_valid_i & in_ready_o;
  assign signed_op = (div_mode_i == DIV_MODE_DIV) || (div_mode_i == DIV_MODE_REM);
  assign is_rem_op = (div_mode_i == DIV_MODE_REM) || (div_mode_i == DIV_MODE_REMU);
  assign s1        = signed_op & operand1_i[DW-1];
  assign s2        = signed_op & operand2_i[DW-1];
  // -2^(DW-1) maps to itself, which is its correct unsigned magnitude.
  assign abs1      = s1 ? -operand1_i : operand1_i;
  assign abs2      = s2 ? -operand2_i : operand2_i;
  assign div_zero  = (operand2_i == '0);

`ifdef UTILS_DIV_EARLY_OUT_EN
  assign early = (abs2 > abs1);
`else
  assign early = 1'b0;
`endif

  assign q_final = q_neg_q ? -dq_q  : dq_q;
  assign r_final = r_neg_q ? -rem_q : rem_q;

  utils_div_step #(.DW(DW)) u_step (
    .rem_i (rem_q),
    .msb_i (dq_q[DW-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = div_zero ? DONE : (early ? FIX : CALC);
        CALC: if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (out_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  assign res_o      = res_q;
  assign div_zero_o = dz_q;

  // Datapath
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dq_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else if (!flush_i) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            is_rem_q <= is_rem_op;
            q_neg_q  <= s1 ^ s2;
            r_neg_q  <= s1;
            dvs_q    <= abs2;
            cnt_q    <= '0;
            dz_q     <= div_zero;
            if (div_zero) begin
              // RISC-V x/0: quotient all ones, remainder is the raw dividend.
              res_q <= is_rem_op ? operand1_i : '1;
            end else if (early) begin
              dq_q  <= '0;
              rem_q <= abs1;
            end else begin
              dq_q  <= abs1;
              rem_q <= '0;
            end
          end
        end
        CALC: begin
          dq_q  <= {dq_q[DW-2:0], step_q};
          rem_q <= step_rem;
          cnt_q <= cnt_q + CW'(1);
        end
        FIX: begin
          res_q <= is_rem_q ? r_final : q_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_utils_divider_32.sv
module tb_utils_divider_32;

  localparam int DW = 32;
`ifdef UTILS_DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [2:0]    div_mode_i = 3'b101;
  logic [DW-1:0] operand1_i = '0;
  logic [DW-1:0] operand2_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] res_o;
  logic          div_zero_o;

  utils_divider_32 #(.DW(DW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .div_mode_i  (div_mode_i),
    .operand1_i  (operand1_i),
    .operand2_i  (operand2_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .div_zero_o  (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    bit          early;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request, complete the handshake, then scramble the inputs
  // so that anything not captured at accept would corrupt the result.
  task automatic start_op(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    div_mode_i = mode;
    operand1_i = a;
    operand2_i = b;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    div_mode_i = 3'b110;
    operand1_i = 32'hDEADBEEF;
    operand2_i = 32'h00000003;
  endtask

  // Number of cycles after the accept edge until out_valid_o is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_result();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int lat;
    int exp_lat;
    exp_lat = vecs[i].dz ? 1 : ((vecs[i].early && EARLY) ? 2 : DW + 2);
    start_op(vecs[i].mode, vecs[i].a, vecs[i].b);
    wait_valid(lat);
    check($sformatf("vec%0d res", i), res_o, vecs[i].res);
    check($sformatf("vec%0d div_zero", i), 32'(div_zero_o), 32'(vecs[i].dz));
    check($sformatf("vec%0d latency", i), 32'(lat), 32'(exp_lat));
    $display("vec%0d mode=%b a=0x%08h b=0x%08h -> res=0x%08h dz=%0b lat=%0d",
             i, vecs[i].mode, vecs[i].a, vecs[i].b, res_o, div_zero_o, lat);
    release_result();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0};
    vecs[2]  = '{3'b100, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0, 1'b0};
    vecs[3]  = '{3'b110, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[4]  = '{3'b110, 32'd7,          32'hFFFFFFFE,   32'd1,          1'b0, 1'b0};
    vecs[5]  = '{3'b100, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0, 1'b0};
    vecs[6]  = '{3'b100, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1'b0};
    vecs[7]  = '{3'b110, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b0};
    vecs[8]  = '{3'b101, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[9]  = '{3'b111, 32'd5,          32'd0,          32'd5,          1'b1, 1'b0};
    vecs[10] = '{3'b110, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1, 1'b0};
    vecs[11] = '{3'b100, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b1, 1'b0};
    vecs[12] = '{3'b101, 32'd3,          32'd10,         32'd0,          1'b0, 1'b1};
    vecs[13] = '{3'b111, 32'd3,          32'd10,         32'd3,          1'b0, 1'b1};
    vecs[14] = '{3'b110, 32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   1'b0, 1'b1};
    vecs[15] = '{3'b100, 32'hFFFFFFEC,   32'hFFFFFFFA,   32'd3,          1'b0, 1'b0};
    vecs[16] = '{3'b110, 32'hFFFFFFEC,   32'hFFFFFFFA,   32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[17] = '{3'b000, 32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
    vecs[18] = '{3'b101, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[19] = '{3'b111, 32'hFFFFFFFF,   32'd10,         32'd5,          1'b0, 1'b0};
    vecs[20] = '{3'b101, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0, 1'b1};

    // Reset values
    repeat (2) @(negedge clk_i);
    check("reset in_ready", 32'(in_ready_o), 32'd1);
    check("reset out_valid", 32'(out_valid_o), 32'd0);
    check("reset res", res_o, 32'd0);
    check("reset div_zero", 32'(div_zero_o), 32'd0);
    rst_n_i = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_vec(i);
    end

    // Backpressure: result held, requests ignored while out_ready_i is low
    start_op(3'b101, 32'd100, 32'd7);
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'(DW + 2));
    for (int c = 0; c < 10; c++) begin
      in_valid_i = 1'b1;
      operand1_i = 32'd1000 + 32'(c);
      operand2_i = 32'd3;
      div_mode_i = 3'b101;
      @(negedge clk_i);
      check($sformatf("bp hold res c%0d", c), res_o, 32'd14);
      check($sformatf("bp hold ready c%0d", c), 32'({out_valid_o, in_ready_o}), 32'b10);
    end
    in_valid_i = 1'b0;
    release_result();
    @(negedge clk_i);
    check("bp after release", 32'({out_valid_o, in_ready_o}), 32'b01);
    $display("backpressure hold done res=0x%08h", res_o);

    // Flush during CALC at counter = 15
    start_op(3'b101, 32'd100, 32'd7);
    repeat (16) @(negedge clk_i);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush calc state", 32'({out_valid_o, in_ready_o}), 32'b01);
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk_i);
      if (out_valid_o) seen = 1'b1;
    end
    check("flush calc no valid", 32'(seen), 32'd0);
    $display("flush at counter 15 done");

    // Flush beats a simultaneous accept
    @(negedge clk_i);
    div_mode_i = 3'b101;
    operand1_i = 32'd100;
    operand2_i = 32'd0;
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    @(negedge clk_i);
    check("flush vs accept", 32'({out_valid_o, in_ready_o}), 32'b01);
    $display("flush with simultaneous accept done");

    // Flush in DONE clears out_valid_o
    start_op(3'b101, 32'd9, 32'd0);
    wait_valid(lat);
    check("done latency", 32'(lat), 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush done state", 32'({out_valid_o, in_ready_o}), 32'b01);
    $display("flush in DONE done");

    // Asynchronous reset in the middle of CALC
    start_op(3'b101, 32'd100, 32'd7);
    repeat (5) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("async reset state", 32'({out_valid_o, in_ready_o}), 32'b01);
    check("async reset res", res_o, 32'd0);
    check("async reset dz", 32'(div_zero_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    $display("async reset mid-operation done");
    run_vec(3);
    run_vec(9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
